// File: rtl/group_serial_subtractor.sv
// Group-serial unsigned subtractor: D = A - B, one GROUP-bit slice per clock, start/busy/done handshake.
// Optional signed-overflow output enabled by defining GSS_OVF_EN.
`ifndef INPUTSIZE
`define INPUTSIZE 32
`endif
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

module group_serial_subtractor #(
    parameter int WIDTH = `INPUTSIZE,
    parameter int GROUP = `GROUPSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow
`ifdef GSS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / GROUP;
    localparam int KW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k;
    logic              c;
    logic [WIDTH-1:0]  a_sh, b_sh, res, res_nxt;
    logic [GROUP:0]    sl;
    logic              last;
`ifdef GSS_OVF_EN
    logic              a_msb, b_msb;
`endif

    // Two's-complement slice subtract: x + ~y + cin, carry in the top bit.
    function automatic logic [GROUP:0] sub_slice(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, ~y} + {{GROUP{1'b0}}, cin};
    endfunction

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign last = (k == KW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sl      = sub_slice(a_sh[GROUP-1:0], b_sh[GROUP-1:0], c);
        res_nxt = res;
        res_nxt[int'(k)*GROUP +: GROUP] = sl[GROUP-1:0];
    end

    // Control and visible results: reset, and only updated on accept / RUN->DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            c      <= 1'b0;
            d      <= '0;
            borrow <= 1'b0;
`ifdef GSS_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                k <= '0;
                c <= 1'b1;
            end else if (state == RUN) begin
                k <= k + KW'(1);
                c <= sl[GROUP];
                if (last) begin
                    d      <= res_nxt;
                    borrow <= ~sl[GROUP];
`ifdef GSS_OVF_EN
                    ovf    <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
`endif
                end
            end
        end
    end

    // Operand shift registers and partial result; no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
`ifdef GSS_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == RUN) begin
            a_sh <= a_sh >> GROUP;
            b_sh <= b_sh >> GROUP;
            res  <= res_nxt;
        end
    end

endmodule

// File: tb/tb_group_serial_subtractor.sv
// Directed self-checking bench for group_serial_subtractor (WIDTH=32, GROUP=4, N=8).
`timescale 1ns/1ps
module tb_group_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b, d;
    logic        busy, done, borrow;
`ifdef GSS_OVF_EN
    logic        ovf;
`endif
    int checks = 0;
    int failures = 0;

    group_serial_subtractor #(.WIDTH(32), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .borrow(borrow)
`ifdef GSS_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with the given operands and wait (bounded) for done; lat = cycles after the accepting edge.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (d !== 32'h0)    begin failures++; $display("FAIL reset_d got=%h exp=00000000", d); end
        checks++; if (borrow !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
`ifdef GSS_OVF_EN
        checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        a = 32'h0000000A; b = 32'h00000003; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy cyc=%0d got=%b exp=1", i, busy); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_early_done cyc=%0d got=%b exp=0", i, done); end
            tick();
        end
        checks++; if (done !== 1'b1)      begin failures++; $display("FAIL basic_done9 got=%b exp=1", done); end
        checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL basic_busy9 got=%b exp=1", busy); end
        checks++; if (d !== 32'h00000007) begin failures++; $display("FAIL basic_d got=%h exp=00000007", d); end
        checks++; if (borrow !== 1'b0)    begin failures++; $display("FAIL basic_borrow got=%b exp=0", borrow); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_idle busy=%b done=%b exp=0/0", busy, done); end
        checks++; if (d !== 32'h00000007) begin failures++; $display("FAIL basic_hold got=%h exp=00000007", d); end
    endtask

    task automatic test_borrow();
        int lat;
        do_op(32'h00000003, 32'h00000005, lat);
        checks++; if (lat !== 9)          begin failures++; $display("FAIL borrow_lat got=%0d exp=9", lat); end
        checks++; if (d !== 32'hFFFFFFFE) begin failures++; $display("FAIL borrow_d got=%h exp=fffffffe", d); end
        checks++; if (borrow !== 1'b1)    begin failures++; $display("FAIL borrow_b got=%b exp=1", borrow); end
        tick();
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        checks++; if (d !== 32'h00000000) begin failures++; $display("FAIL equal_d got=%h exp=00000000", d); end
        checks++; if (borrow !== 1'b0)    begin failures++; $display("FAIL equal_b got=%b exp=0", borrow); end
        tick();
        do_op(32'h12345678, 32'h00000000, lat);
        checks++; if (d !== 32'h12345678) begin failures++; $display("FAIL bzero_d got=%h exp=12345678", d); end
        checks++; if (borrow !== 1'b0)    begin failures++; $display("FAIL bzero_b got=%b exp=0", borrow); end
        tick();
        do_op(32'h0F0F0F0F, 32'hF0F0F0F1, lat);
        checks++; if (d !== 32'h1E1E1E1E) begin failures++; $display("FAIL mixed_d got=%h exp=1e1e1e1e", d); end
        checks++; if (borrow !== 1'b1)    begin failures++; $display("FAIL mixed_b got=%b exp=1", borrow); end
        tick();
    endtask

`ifdef GSS_OVF_EN
    task automatic test_ovf();
        int lat;
        do_op(32'h80000000, 32'h00000001, lat);
        checks++; if (d !== 32'h7FFFFFFF) begin failures++; $display("FAIL ovf_d got=%h exp=7fffffff", d); end
        checks++; if (borrow !== 1'b0)    begin failures++; $display("FAIL ovf_b got=%b exp=0", borrow); end
        checks++; if (ovf !== 1'b1)       begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        tick();
        do_op(32'h00000005, 32'h00000003, lat);
        checks++; if (ovf !== 1'b0)       begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
        checks++; if (d !== 32'h00000002) begin failures++; $display("FAIL ovf_d2 got=%h exp=00000002", d); end
        tick();
    endtask
`endif

    task automatic test_ignore_start();
        int ndone = 0;
        a = 32'h00000100; b = 32'h00000001; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 32'hDEADBEEF; b = 32'h00001234; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 4; cyc <= 16; cyc++) begin
            if (done) begin
                ndone++;
                checks++; if (cyc !== 9)          begin failures++; $display("FAIL ignore_cyc got=%0d exp=9", cyc); end
                checks++; if (d !== 32'h000000FF) begin failures++; $display("FAIL ignore_d got=%h exp=000000ff", d); end
            end
            tick();
        end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_ndone got=%0d exp=1", ndone); end
        checks++; if (d !== 32'h000000FF) begin failures++; $display("FAIL ignore_hold got=%h exp=000000ff", d); end
    endtask

    task automatic test_abort();
        int ndone = 0;
        int lat;
        a = 32'h00000050; b = 32'h00000020; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (d !== 32'h0)     begin failures++; $display("FAIL abort_d got=%h exp=00000000", d); end
        checks++; if (done !== 1'b0)   begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            tick();
        end
        checks++; if (ndone !== 0)     begin failures++; $display("FAIL abort_pulse got=%0d exp=0", ndone); end
        do_op(32'h00000009, 32'h00000004, lat);
        checks++; if (lat !== 9)       begin failures++; $display("FAIL abort_relat got=%0d exp=9", lat); end
        checks++; if (d !== 32'h5)     begin failures++; $display("FAIL abort_red got=%h exp=00000005", d); end
        tick();
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        a = 32'd20; b = 32'd7; start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 22; cyc++) begin
            if (done) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            if (cyc == 19) start = 1'b0;
            tick();
        end
        checks++; if (first !== 9)   begin failures++; $display("FAIL b2b_first got=%0d exp=9", first); end
        checks++; if (second !== 19) begin failures++; $display("FAIL b2b_second got=%0d exp=19", second); end
        checks++; if (d !== 32'd13)  begin failures++; $display("FAIL b2b_d got=%h exp=0000000d", d); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
`ifdef GSS_OVF_EN
        test_ovf();
`endif
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
